ex_stage: RTL and testbench

//  Execute stage of the 5-stage 16-bit pipeline, directly downstream of the forwarding unit.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/alu16.sv | 35 +++
 rtl/ex_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit pipeline: ALU op codes, forwarding selects,
// default widths and the EX-stage FSM state type.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLL   = 4'h5;
    localparam logic [3:0] OP_SRL   = 4'h6;
    localparam logic [3:0] OP_SRA   = 4'h7;
    localparam logic [3:0] OP_SLT   = 4'h8;
    localparam logic [3:0] OP_SLTU  = 4'h9;
    localparam logic [3:0] OP_PASSB = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/alu16.sv
// Single-cycle combinational ALU for ops 0-A; every other code yields zero
// (MUL is handled by the sequential multiplier in ex_stage).
module alu16
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [3:0] shamt;
    assign shamt = b[3:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_SLL:   y = a << shamt;
            OP_SRL:   y = a >> shamt;
            OP_SRA:   y = W'($signed(a) >>> shamt);
            OP_SLT:   y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  y = {{(W-1){1'b0}}, (a < b)};
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding muxes, single-cycle ALU, DATA_W-step
// shift-add multiplier FSM, and the EX/MEM pipeline register.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_valid,
    input  logic [3:0]        idex_alu_op,
    input  logic [DATA_W-1:0] idex_rs1_data,
    input  logic [DATA_W-1:0] idex_rs2_data,
    input  logic [DATA_W-1:0] idex_imm,
    input  logic              idex_use_imm,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_reg_write,
    input  logic              idex_mem_read,
    input  logic              idex_mem_write,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [DATA_W-1:0] exmem_fwd_data,
    input  logic [DATA_W-1:0] memwb_fwd_data,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              ex_busy,
    output logic              exmem_valid,
    output logic [DATA_W-1:0] exmem_alu_result,
    output logic [DATA_W-1:0] exmem_store_data,
    output logic [REG_AW-1:0] exmem_rd,
    output logic              exmem_reg_write,
    output logic              exmem_mem_read,
    output logic              exmem_mem_write,
    output logic              exmem_zero
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // Valid/ready contract: EX accepts ID/EX whenever ex_busy is low and mem_stall
    // is low; while ex_busy is high the upstream must hold ID/EX unchanged.

    logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_y;

    always_comb begin
        case (forward_a)
            FWD_EXMEM: op_a = exmem_fwd_data;
            FWD_MEMWB: op_a = memwb_fwd_data;
            default:   op_a = idex_rs1_data;
        endcase
        case (forward_b)
            FWD_EXMEM: fwd_b = exmem_fwd_data;
            FWD_MEMWB: fwd_b = memwb_fwd_data;
            default:   fwd_b = idex_rs2_data;
        endcase
        op_b = idex_use_imm ? idex_imm : fwd_b;
    end

    alu16 #(.W(DATA_W)) u_alu (
        .op (idex_alu_op),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

    ex_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [DATA_W-1:0] m_store_q, m_store_d;
    logic [REG_AW-1:0] m_rd_q, m_rd_d;
    logic              m_rw_q, m_rw_d, m_mr_q, m_mr_d, m_mw_q, m_mw_d;

    logic              ex_valid_q, ex_valid_d, ex_rw_q, ex_rw_d;
    logic              ex_mr_q, ex_mr_d, ex_mw_q, ex_mw_d, ex_zero_q, ex_zero_d;
    logic [DATA_W-1:0] ex_result_q, ex_result_d, ex_store_q, ex_store_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

    logic              busy, is_launch, ld_en, ld_live, ld_rw, ld_mr, ld_mw;
    logic [DATA_W-1:0] ld_result, ld_store, step_acc;
    logic [REG_AW-1:0] ld_rd;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        m_store_d = m_store_q;
        m_rd_d    = m_rd_q;
        m_rw_d    = m_rw_q;
        m_mr_d    = m_mr_q;
        m_mw_d    = m_mw_q;
        busy      = 1'b0;
        ld_en     = 1'b0;
        ld_live   = 1'b0;
        ld_result = '0;
        ld_store  = '0;
        ld_rd     = '0;
        ld_rw     = 1'b0;
        ld_mr     = 1'b0;
        ld_mw     = 1'b0;
        step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
        is_launch = (state_q == ST_IDLE) && idex_valid && (idex_alu_op == OP_MUL);

        if (flush) begin
            ld_en   = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            if (is_launch) begin
                busy = 1'b1;
            end else if (state_q == ST_MUL) begin
                busy = (cnt_q != CNT_LAST);
            end

            if (!mem_stall) begin
                ld_en = 1'b1;
                case (state_q)
                    ST_IDLE: begin
                        if (is_launch) begin
                            state_d   = ST_MUL;
                            cnt_d     = '0;
                            acc_d     = '0;
                            mcand_d   = op_a;
                            mplier_d  = op_b;
                            m_store_d = fwd_b;
                            m_rd_d    = idex_rd;
                            m_rw_d    = idex_reg_write;
                            m_mr_d    = idex_mem_read;
                            m_mw_d    = idex_mem_write;
                        end else if (idex_valid) begin
                            ld_live   = 1'b1;
                            ld_result = alu_y;
                            ld_store  = fwd_b;
                            ld_rd     = idex_rd;
                            ld_rw     = idex_reg_write;
                            ld_mr     = idex_mem_read;
                            ld_mw     = idex_mem_write;
                        end
                    end
                    ST_MUL: begin
                        acc_d    = step_acc;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d   = ST_IDLE;
                            cnt_d     = '0;
                            ld_live   = 1'b1;
                            ld_result = step_acc;
                            ld_store  = m_store_q;
                            ld_rd     = m_rd_q;
                            ld_rw     = m_rw_q;
                            ld_mr     = m_mr_q;
                            ld_mw     = m_mw_q;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Bubbles clear the whole record so a dead slot can never look like a result.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_result_d = ex_result_q;
        ex_store_d  = ex_store_q;
        ex_rd_d     = ex_rd_q;
        ex_rw_d     = ex_rw_q;
        ex_mr_d     = ex_mr_q;
        ex_mw_d     = ex_mw_q;
        ex_zero_d   = ex_zero_q;
        if (ld_en) begin
            ex_valid_d  = ld_live;
            ex_result_d = ld_result;
            ex_store_d  = ld_store;
            ex_rd_d     = ld_rd;
            ex_rw_d     = ld_rw;
            ex_mr_d     = ld_mr;
            ex_mw_d     = ld_mw;
            ex_zero_d   = ld_live && (ld_result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            m_store_q   <= '0;
            m_rd_q      <= '0;
            m_rw_q      <= 1'b0;
            m_mr_q      <= 1'b0;
            m_mw_q      <= 1'b0;
            ex_valid_q  <= 1'b0;
            ex_result_q <= '0;
            ex_store_q  <= '0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_mw_q     <= 1'b0;
            ex_zero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            m_store_q   <= m_store_d;
            m_rd_q      <= m_rd_d;
            m_rw_q      <= m_rw_d;
            m_mr_q      <= m_mr_d;
            m_mw_q      <= m_mw_d;
            ex_valid_q  <= ex_valid_d;
            ex_result_q <= ex_result_d;
            ex_store_q  <= ex_store_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            ex_mw_q     <= ex_mw_d;
            ex_zero_q   <= ex_zero_d;
        end
    end

    // A launch decode during reset must not leak out as a busy request.
    assign ex_busy          = busy & rst_n;
    assign exmem_valid      = ex_valid_q;
    assign exmem_alu_result = ex_result_q;
    assign exmem_store_data = ex_store_q;
    assign exmem_rd         = ex_rd_q;
    assign exmem_reg_write  = ex_rw_q;
    assign exmem_mem_read   = ex_mr_q;
    assign exmem_mem_write  = ex_mw_q;
    assign exmem_zero       = ex_zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle vectors plus hand-written
// multiply, flush, stall and reset sequences.
module tb_ex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idex_valid;
    logic [3:0]  idex_alu_op;
    logic [15:0] idex_rs1_data, idex_rs2_data, idex_imm;
    logic        idex_use_imm;
    logic [3:0]  idex_rd;
    logic        idex_reg_write, idex_mem_read, idex_mem_write;
    logic [1:0]  forward_a, forward_b;
    logic [15:0] exmem_fwd_data, memwb_fwd_data;
    logic        flush, mem_stall;
    logic        ex_busy, exmem_valid;
    logic [15:0] exmem_alu_result, exmem_store_data;
    logic [3:0]  exmem_rd;
    logic        exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_zero;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .idex_valid       (idex_valid),
        .idex_alu_op      (idex_alu_op),
        .idex_rs1_data    (idex_rs1_data),
        .idex_rs2_data    (idex_rs2_data),
        .idex_imm         (idex_imm),
        .idex_use_imm     (idex_use_imm),
        .idex_rd          (idex_rd),
        .idex_reg_write   (idex_reg_write),
        .idex_mem_read    (idex_mem_read),
        .idex_mem_write   (idex_mem_write),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .exmem_fwd_data   (exmem_fwd_data),
        .memwb_fwd_data   (memwb_fwd_data),
        .flush            (flush),
        .mem_stall        (mem_stall),
        .ex_busy          (ex_busy),
        .exmem_valid      (exmem_valid),
        .exmem_alu_result (exmem_alu_result),
        .exmem_store_data (exmem_store_data),
        .exmem_rd         (exmem_rd),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_mem_write  (exmem_mem_write),
        .exmem_zero       (exmem_zero)
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [15:0] rs1, rs2, imm;
        logic        ui;
        logic [1:0]  fa, fb;
        logic [15:0] exf, wbf;
        logic        rw, mr, mw;
        logic [15:0] e_res, e_st;
        logic        e_z;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [3:0] op,
                                input logic [15:0] rs1, rs2, imm, input logic ui,
                                input logic [1:0] fa, fb, input logic [15:0] exf, wbf,
                                input logic rw, mr, mw,
                                input logic [15:0] e_res, e_st, input logic e_z);
        vec_t t;
        t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.ui = ui;
        t.fa = fa; t.fb = fb; t.exf = exf; t.wbf = wbf;
        t.rw = rw; t.mr = mr; t.mw = mw;
        t.e_res = e_res; t.e_st = e_st; t.e_z = e_z;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t t, input logic [3:0] rd);
        idex_valid = t.v; idex_alu_op = t.op;
        idex_rs1_data = t.rs1; idex_rs2_data = t.rs2; idex_imm = t.imm;
        idex_use_imm = t.ui; forward_a = t.fa; forward_b = t.fb;
        exmem_fwd_data = t.exf; memwb_fwd_data = t.wbf;
        idex_rd = rd; idex_reg_write = t.rw; idex_mem_read = t.mr; idex_mem_write = t.mw;
    endtask

    task automatic drive_mul(input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd);
        drive(mk(1, OP_MUL, a, b, 16'h0, 0, 2'b00, 2'b00, 16'h0, 16'h0, 1, 0, 0, 0, 0, 0), rd);
    endtask

    task automatic cycle;
        @(posedge clk);
        #1;
    endtask

    // Runs cycles until EX/MEM shows a live result; optional mem_stall window.
    task automatic run_mul(input int stall_at, input int stall_len,
                           output int lat, output int busy_cnt);
        bit found;
        lat = 0; busy_cnt = 0; found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            mem_stall = (lat >= stall_at) && (lat < stall_at + stall_len);
            #1;
            if (ex_busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
            if (exmem_valid) found = 1;
        end
        mem_stall  = 1'b0;
        idex_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int lat, bc, seen;

        //                v  op        rs1      rs2      imm      ui fa     fb     exf      wbf      rw mr mw e_res    e_st     z
        vecs.push_back(mk(1, OP_ADD,   16'h0001,16'h0000,16'h0003,1, 2'b10, 2'b00, 16'h0005,16'h0009,1, 0, 0, 16'h0008,16'h0000,0));
        vecs.push_back(mk(1, OP_ADD,   16'h0100,16'h0007,16'h0004,1, 2'b11, 2'b01, 16'h0000,16'h00FF,0, 0, 1, 16'h0104,16'h00FF,0));
        vecs.push_back(mk(1, OP_SRA,   16'h8000,16'h0000,16'h0003,1, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'hF000,16'h0000,0));
        vecs.push_back(mk(1, OP_SLT,   16'hFFFF,16'h0001,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h0001,16'h0001,0));
        vecs.push_back(mk(1, OP_SLTU,  16'hFFFF,16'h0001,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h0000,16'h0001,1));
        vecs.push_back(mk(1, OP_SUB,   16'h0005,16'h0005,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h0000,16'h0005,1));
        vecs.push_back(mk(1, OP_AND,   16'hF0F0,16'h0FF0,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h00F0,16'h0FF0,0));
        vecs.push_back(mk(1, OP_OR,    16'hF000,16'h000F,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'hF00F,16'h000F,0));
        vecs.push_back(mk(1, OP_XOR,   16'hFFFF,16'h00FF,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'hFF00,16'h00FF,0));
        vecs.push_back(mk(1, OP_SLL,   16'h0001,16'h001F,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h8000,16'h001F,0));
        vecs.push_back(mk(1, OP_SRL,   16'h8000,16'h0004,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h0800,16'h0004,0));
        vecs.push_back(mk(1, OP_PASSB, 16'h0001,16'h0002,16'h0000,0, 2'b00, 2'b10, 16'hBEEF,16'h0000,1, 0, 0, 16'hBEEF,16'hBEEF,0));
        vecs.push_back(mk(1, 4'hC,     16'h0003,16'h0004,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h0000,16'h0004,1));
        vecs.push_back(mk(0, OP_ADD,   16'h0003,16'h0004,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 1, 1, 16'h0000,16'h0000,0));
        vecs.push_back(mk(1, OP_SUB,   16'h0000,16'h0001,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'hFFFF,16'h0001,0));
        vecs.push_back(mk(1, OP_ADD,   16'h0000,16'h0000,16'hFFFF,1, 2'b01, 2'b00, 16'h0000,16'h1000,1, 1, 0, 16'h0FFF,16'h0000,0));
        vecs.push_back(mk(1, 4'hF,     16'hFFFF,16'hFFFF,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h0000,16'hFFFF,1));
        vecs.push_back(mk(1, OP_SRA,   16'h4000,16'h0011,16'h0000,0, 2'b00, 2'b00, 16'h0000,16'h0000,1, 0, 0, 16'h2000,16'h0011,0));

        // Reset state, with a MUL launch presented on the inputs.
        rst_n = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        drive_mul(16'd300, 16'd200, 4'd3);
        repeat (2) cycle();
        chk("reset_busy",   {15'b0, ex_busy}, 16'h0);
        chk("reset_valid",  {15'b0, exmem_valid}, 16'h0);
        chk("reset_result", exmem_alu_result, 16'h0);
        chk("reset_store",  exmem_store_data, 16'h0);
        chk("reset_ctrl",   {10'b0, exmem_rd, exmem_reg_write, exmem_mem_read}, 16'h0);
        chk("reset_zero",   {14'b0, exmem_mem_write, exmem_zero}, 16'h0);
        idex_valid = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Single-cycle table.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i], 4'(i));
            #1;
            chk($sformatf("v%0d_busy", i), {15'b0, ex_busy}, 16'h0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {15'b0, exmem_valid}, {15'b0, vecs[i].v});
            chk($sformatf("v%0d_rw", i), {15'b0, exmem_reg_write}, {15'b0, vecs[i].v & vecs[i].rw});
            chk($sformatf("v%0d_mr", i), {15'b0, exmem_mem_read}, {15'b0, vecs[i].v & vecs[i].mr});
            chk($sformatf("v%0d_mw", i), {15'b0, exmem_mem_write}, {15'b0, vecs[i].v & vecs[i].mw});
            if (vecs[i].v) begin
                chk($sformatf("v%0d_result", i), exmem_alu_result, vecs[i].e_res);
                chk($sformatf("v%0d_store", i), exmem_store_data, vecs[i].e_st);
                chk($sformatf("v%0d_rd", i), {12'b0, exmem_rd}, {12'b0, 4'(i)});
                chk($sformatf("v%0d_zero", i), {15'b0, exmem_zero}, {15'b0, vecs[i].e_z});
            end
        end

        // MUL 300*200.
        drive_mul(16'd300, 16'd200, 4'd3);
        run_mul(100, 0, lat, bc);
        chk("mul1_latency", 16'(lat), 16'd17);
        chk("mul1_busy_cycles", 16'(bc), 16'd16);
        chk("mul1_result", exmem_alu_result, 16'hEA60);
        chk("mul1_rd", {12'b0, exmem_rd}, 16'd3);
        chk("mul1_rw", {15'b0, exmem_reg_write}, 16'd1);
        cycle();
        chk("mul1_no_relaunch", {15'b0, exmem_valid}, 16'd0);

        // MUL 0x1234*0x0010.
        drive_mul(16'h1234, 16'h0010, 4'd5);
        run_mul(100, 0, lat, bc);
        chk("mul2_latency", 16'(lat), 16'd17);
        chk("mul2_result", exmem_alu_result, 16'h2340);
        chk("mul2_rd", {12'b0, exmem_rd}, 16'd5);
        cycle();

        // MUL with a 3-cycle mem_stall in the middle.
        drive_mul(16'd300, 16'd200, 4'd7);
        run_mul(5, 3, lat, bc);
        chk("mulstall_latency", 16'(lat), 16'd20);
        chk("mulstall_busy_cycles", 16'(bc), 16'd19);
        chk("mulstall_result", exmem_alu_result, 16'hEA60);
        chk("mulstall_rd", {12'b0, exmem_rd}, 16'd7);
        cycle();

        // Flush at cnt=7, then ADD completes at latency 1.
        drive_mul(16'd300, 16'd200, 4'd3);
        repeat (8) cycle();
        #1;
        chk("flush_pre_busy", {15'b0, ex_busy}, 16'd1);
        flush = 1'b1;
        #1;
        chk("flush_busy", {15'b0, ex_busy}, 16'd0);
        cycle();
        chk("flush_bubble", {15'b0, exmem_valid}, 16'd0);
        flush = 1'b0;
        drive(mk(1, OP_ADD, 16'h0002, 16'h0003, 16'h0, 0, 2'b00, 2'b00, 16'h0, 16'h0, 1, 0, 0, 0, 0, 0), 4'd9);
        #1;
        chk("post_flush_busy", {15'b0, ex_busy}, 16'd0);
        cycle();
        chk("post_flush_valid", {15'b0, exmem_valid}, 16'd1);
        chk("post_flush_result", exmem_alu_result, 16'h0005);
        idex_valid = 1'b0;
        cycle();

        // Reset asserted mid-MUL.
        drive_mul(16'd300, 16'd200, 4'd3);
        repeat (6) cycle();
        rst_n = 1'b0;
        #1;
        chk("rstmul_busy", {15'b0, ex_busy}, 16'd0);
        chk("rstmul_valid", {15'b0, exmem_valid}, 16'd0);
        chk("rstmul_result", exmem_alu_result, 16'h0);
        idex_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (exmem_valid) seen++;
        end
        chk("rstmul_no_product", 16'(seen), 16'd0);
        chk("rstmul_idle_busy", {15'b0, ex_busy}, 16'd0);
        drive(mk(1, OP_ADD, 16'h0007, 16'h0001, 16'h0, 0, 2'b00, 2'b00, 16'h0, 16'h0, 1, 0, 0, 0, 0, 0), 4'd2);
        cycle();
        chk("rstmul_add_result", exmem_alu_result, 16'h0008);
        chk("rstmul_add_valid", {15'b0, exmem_valid}, 16'd1);
        idex_valid = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
